// File: rtl/seg7_scan_2.sv
// Two-digit multiplexed 7-segment scanner with per-frame digit snapshot and anode blanking.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module seg7_scan_2 #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  typedef enum logic {
    SCAN_ONES,
    SCAN_TENS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ones_q;
  logic [3:0]       tens_q;
  logic [6:0]       seg_d;
  logic [1:0]       an_d;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h3F;
    endcase
  endfunction

  always_comb begin
    // NOTE: defaults first so every path assigns seg_d/an_d and no latch is inferred.
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    // Signed compare keeps BLANK_CYCLES=0 meaningful (never blanking).
    if (int'(cnt) >= BLANK_CYCLES) begin
      if (state == SCAN_ONES) begin
        an_d  = AN_ONES;
        seg_d = enc(ones_q);
      end else begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (tens_q != 4'd0) begin
          an_d  = AN_TENS;
          seg_d = enc(tens_q);
        end
`else
        an_d  = AN_TENS;
        seg_d = enc(tens_q);
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= SCAN_ONES;
      cnt    <= '0;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      seg    <= SEG_OFF;
      an     <= AN_OFF;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      seg <= seg_d;
      an  <= an_d;
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= (state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
        // Digits are sampled once per frame so a frame never mixes two pairs.
        if (state == SCAN_TENS) begin
          ones_q <= digit_1;
          tens_q <= digit_2;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_2.sv
// Self-checking bench for seg7_scan_2 (REFRESH_DIV=4, BLANK_CYCLES=1) against a frame-position model.
module tb_seg7_scan_2;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 2 * DIV;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] digit_1 = 4'd0;
  logic [3:0] digit_2 = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  seg7_scan_2 #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .CLK(CLK), .RST_N(RST_N), .digit_1(digit_1), .digit_2(digit_2), .seg(seg), .an(an)
  );

  always #5 CLK = ~CLK;

  // Model: position within the frame of the current cycle, plus the frame's digit pair.
  logic [6:0] enc_tab [16];
  int         m_pos  = 0;
  int         m_ones = 0;
  int         m_tens = 0;
  logic [6:0] exp_seg = 7'h7F;
  logic [1:0] exp_an  = 2'b11;

  initial begin
    enc_tab[0] = 7'h40; enc_tab[1] = 7'h79; enc_tab[2] = 7'h24; enc_tab[3] = 7'h30;
    enc_tab[4] = 7'h19; enc_tab[5] = 7'h12; enc_tab[6] = 7'h02; enc_tab[7] = 7'h78;
    enc_tab[8] = 7'h00; enc_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) enc_tab[i] = 7'h3F;
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pos = 0; m_ones = 0; m_tens = 0;
      exp_seg = 7'h7F; exp_an = 2'b11;
    end else begin
      exp_seg = 7'h7F; exp_an = 2'b11;
      if ((m_pos % DIV) >= BLANK) begin
        if (m_pos < DIV) begin
          exp_an = 2'b10; exp_seg = enc_tab[m_ones];
        end else begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
          if (m_tens != 0) begin exp_an = 2'b01; exp_seg = enc_tab[m_tens]; end
`else
          exp_an = 2'b01; exp_seg = enc_tab[m_tens];
`endif
        end
      end
      if (m_pos == FRAME - 1) begin
        m_ones = int'(digit_1);
        m_tens = int'(digit_2);
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] e_an, input logic [6:0] e_seg);
    check({name, "_an"}, {6'd0, an}, {6'd0, e_an});
    check({name, "_seg"}, {1'b0, seg}, {1'b0, e_seg});
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_an", {6'd0, an}, {6'd0, exp_an});
      check("model_seg", {1'b0, seg}, {1'b0, exp_seg});
      check("an_not_00", {7'd0, an == 2'b00}, 8'd0);
    end
  end

  task automatic wait_pos(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(negedge CLK);
      if (m_pos == p) hit = 1'b1;
    end
    check("wait_pos", {7'd0, hit}, 8'd1);
  endtask

  logic [1:0] lit_an  [FRAME];
  logic [6:0] lit_seg [FRAME];
  int         pairs   [100];

  initial begin
    // Second frame of 73: one blank + three ones cycles, one blank + three tens cycles.
    lit_an  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    lit_seg = '{7'h7F, 7'h30, 7'h30, 7'h30, 7'h7F, 7'h78, 7'h78, 7'h78};

    #1 RST_N = 1'b0;
    #1 chk_out("reset_async", 2'b11, 7'h7F);
    cmp_en = 1'b1;
    repeat (2) @(negedge CLK);
    chk_out("reset_hold", 2'b11, 7'h7F);

    digit_2 = 4'd7; digit_1 = 4'd3;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk_out("first_slot_blank", 2'b11, 7'h7F);
    @(negedge CLK);
    chk_out("first_frame_zero", 2'b10, 7'h40);

    wait_pos(0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      chk_out($sformatf("frame73_c%0d", i), lit_an[i], lit_seg[i]);
    end

    // Mid-slot change of the ones digit must wait for the next frame.
    wait_pos(2);
    digit_1 = 4'd5;
    @(negedge CLK); chk_out("snap_hold_a", 2'b10, 7'h30);
    @(negedge CLK); chk_out("snap_hold_b", 2'b10, 7'h30);
    wait_pos(6); chk_out("snap_tens", 2'b01, 7'h78);
    wait_pos(2); chk_out("snap_new", 2'b10, 7'h12);

    digit_1 = 4'd12;
    wait_pos(0);
    wait_pos(2); chk_out("invalid_dash", 2'b10, 7'h3F);

    digit_2 = 4'd0; digit_1 = 4'd5;
    wait_pos(0);
    wait_pos(2); chk_out("lz_ones", 2'b10, 7'h12);
    wait_pos(6);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk_out("lz_tens_blank", 2'b11, 7'h7F);
    @(negedge CLK); chk_out("lz_tens_blank2", 2'b11, 7'h7F);
`else
    chk_out("lz_tens_zero", 2'b01, 7'h40);
    @(negedge CLK); chk_out("lz_tens_zero2", 2'b01, 7'h40);
`endif

    // 73 -> 15 mid-frame: the tens slot keeps 7 until the following frame.
    digit_2 = 4'd7; digit_1 = 4'd3;
    wait_pos(0);
    wait_pos(3);
    digit_2 = 4'd1; digit_1 = 4'd5;
    wait_pos(6); chk_out("chg_tens_old", 2'b01, 7'h78);
    wait_pos(6); chk_out("chg_tens_new", 2'b01, 7'h79);

    // Sweep all pairs in shuffled order, changing inputs at random points mid-frame.
    for (int i = 0; i < 100; i++) pairs[i] = i;
    for (int i = 99; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = t;
    end
    for (int i = 0; i < 100; i++) begin
      digit_2 = 4'(pairs[i] / 10);
      digit_1 = 4'(pairs[i] % 10);
      wait_pos(0);
      repeat ($urandom_range(0, FRAME - 2)) @(negedge CLK);
    end

    // Reset in the middle of a ones slot aborts it without a clock edge.
    wait_pos(3);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_out("midslot_reset", 2'b11, 7'h7F);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK); chk_out("resume_blank", 2'b11, 7'h7F);
    @(negedge CLK); chk_out("resume_ones0", 2'b10, 7'h40);
    repeat (FRAME) @(negedge CLK);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
